// File: rtl/ppu_write_sequencer.sv
// Queues host PPU register writes and replays them onto the PPU bus during vblank.
// Entries left over when vblank closes are kept, and draining resumes at the next vblank.
//
// state | meaning
// IDLE  | waiting for the host to commit a batch
// ARMED | batch committed, waiting for a vblank rising edge
// DRAIN | inside vblank, issuing one queued write per cycle
// DONE  | batch fully issued, pulsing frame_done
module ppu_write_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_addr,
    input  logic [31:0] in_data,
    input  logic        commit,
    input  logic        irq,
    output logic [11:0] address,
    output logic [31:0] write_data,
    output logic        write,
    output logic        chipselect,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, ARMED, DRAIN, DONE} state_t;

    state_t      state;
    logic [11:0] addr_mem [16];
    logic [31:0] data_mem [16];
    logic [3:0]  wr_ptr;
    logic [3:0]  rd_ptr;
    logic [4:0]  count;
    logic        irq_q;
    logic        push;
    logic        pop;
    logic        vblank_start;

    assign in_ready     = (count < 5'd16);
    assign push         = in_valid && in_ready;
    assign vblank_start = irq && !irq_q;

    // The vblank edge cycle already pops, so the first strobe lands one cycle after irq rises.
    assign pop = (count != 5'd0) &&
                 (((state == ARMED) && vblank_start) || ((state == DRAIN) && irq));

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= in_addr;
            data_mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= 4'd0;
            rd_ptr     <= 4'd0;
            count      <= 5'd0;
            irq_q      <= 1'b0;
            address    <= 12'd0;
            write_data <= 32'd0;
            write      <= 1'b0;
            chipselect <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            irq_q <= irq;

            if (push) wr_ptr <= wr_ptr + 4'd1;
            if (pop)  rd_ptr <= rd_ptr + 4'd1;

            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase

            write      <= pop;
            chipselect <= pop;
            if (pop) begin
                address    <= addr_mem[rd_ptr];
                write_data <= data_mem[rd_ptr];
            end

            frame_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (commit) begin
                        state   <= ARMED;
                        busy    <= 1'b1;
                        overrun <= 1'b0;
                    end
                end
                ARMED: begin
                    if (vblank_start) state <= DRAIN;
                end
                DRAIN: begin
                    // A push landing on an empty queue keeps us here so it drains this window.
                    if ((count == 5'd0) && !push) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end else if (!irq && (count != 5'd0)) begin
                        state   <= ARMED;
                        overrun <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_write_sequencer.sv
// Bench for ppu_write_sequencer: a queue of accepted commands is the reference; the bus
// monitor collects strobes, and each scenario checks them against the queue and vblank arithmetic.
module tb_ppu_write_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_addr = 12'd0;
    logic [31:0] in_data = 32'd0;
    logic        commit = 1'b0;
    logic        irq = 1'b0;
    logic [11:0] address;
    logic [31:0] write_data;
    logic        write;
    logic        chipselect;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    ppu_write_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .commit     (commit),
        .irq        (irq),
        .address    (address),
        .write_data (write_data),
        .write      (write),
        .chipselect (chipselect),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [43:0] exp_q[$];
    logic [43:0] obs[$];
    int          obs_cyc[$];
    int          fd_cnt = 0;
    int          fd_cyc = 0;
    int          accept_obs = 0;
    int          rise_cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            if (write) begin
                obs.push_back({address, write_data});
                obs_cyc.push_back(cyc);
            end
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            checks++;
            if (write !== chipselect) begin
                errors++;
                $display("FAIL strobe_pair write=%b chipselect=%b at cycle %0d", write, chipselect, cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic clear_scoreboard();
        obs.delete();
        obs_cyc.delete();
        fd_cnt = 0;
    endtask

    task automatic push_cmd(input logic [11:0] a, input logic [31:0] d);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout in_ready=%b required=1", in_ready);
        end else begin
            exp_q.push_back({a, d});
        end
        @(posedge clk);
        accept_obs = obs.size();
        #1 in_valid = 1'b0;
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++)
            push_cmd(12'($urandom_range(0, 4095)), $urandom());
    endtask

    task automatic do_commit();
        @(negedge clk);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    // irq is sampled high by exactly h rising clock edges
    task automatic irq_window(input int h);
        @(negedge clk);
        irq = 1'b1;
        rise_cyc = cyc;
        repeat (h) @(negedge clk);
        irq = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (write !== 1'b0)       begin errors++; $display("FAIL reset_write got=%b exp=0", write); end
        checks++; if (chipselect !== 1'b0)  begin errors++; $display("FAIL reset_cs got=%b exp=0", chipselect); end
        checks++; if (address !== 12'd0)    begin errors++; $display("FAIL reset_address got=%h exp=0", address); end
        checks++; if (write_data !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", write_data); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (frame_done !== 1'b0)  begin errors++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
        checks++; if (overrun !== 1'b0)     begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [43:0] exp_v;
        logic [43:0] got;
        clear_scoreboard();
        push_cmd(12'h010, 32'hA);
        push_cmd(12'h011, 32'hB);
        push_cmd(12'h200, 32'hC);
        do_commit();
        repeat (2) @(negedge clk);
        irq_window(8);
        repeat (4) @(negedge clk);
        checks++;
        if (obs.size() != 3) begin errors++; $display("FAIL basic_count got=%0d exp=3", obs.size()); end
        for (int i = 0; i < 3; i++) begin
            exp_v = exp_q.pop_front();
            got = (i < obs.size()) ? obs[i] : 'x;
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL basic_order[%0d] got=%h exp=%h", i, got, exp_v); end
            checks++;
            if (i < obs_cyc.size() && obs_cyc[i] != rise_cyc + 1 + i) begin
                errors++; $display("FAIL basic_timing[%0d] got=%0d exp=%0d", i, obs_cyc[i], rise_cyc + 1 + i);
            end
        end
        checks++;
        if (fd_cnt != 1) begin errors++; $display("FAIL basic_fd_count got=%0d exp=1", fd_cnt); end
        checks++;
        if (fd_cyc != rise_cyc + 4) begin errors++; $display("FAIL basic_fd_time got=%0d exp=%0d", fd_cyc, rise_cyc + 4); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got=%b exp=0", busy); end
    endtask

    task automatic test_full();
        logic [43:0] exp_v;
        logic [43:0] got;
        clear_scoreboard();
        push_random(16);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        do_commit();
        repeat (2) @(negedge clk);
        fork
            push_cmd(12'h7FF, 32'hDEAD_BEEF);
            irq_window(22);
        join
        repeat (4) @(negedge clk);
        checks++;
        if (accept_obs < 1) begin errors++; $display("FAIL full_hold got=%0d strobes_before_accept exp>=1", accept_obs); end
        checks++;
        if (obs.size() != 17) begin errors++; $display("FAIL full_count got=%0d exp=17", obs.size()); end
        for (int i = 0; i < 17; i++) begin
            exp_v = exp_q.pop_front();
            got = (i < obs.size()) ? obs[i] : 'x;
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL full_order[%0d] got=%h exp=%h", i, got, exp_v); end
        end
        checks++;
        if (fd_cnt != 1) begin errors++; $display("FAIL full_fd got=%0d exp=1", fd_cnt); end
    endtask

    task automatic test_overrun();
        logic [43:0] exp_v;
        logic [43:0] got;
        clear_scoreboard();
        push_random(10);
        do_commit();
        repeat (2) @(negedge clk);
        irq_window(4);
        repeat (3) @(negedge clk);
        checks++;
        if (obs.size() != 4) begin errors++; $display("FAIL ovr_first_count got=%0d exp=4", obs.size()); end
        for (int i = 0; i < 4; i++) begin
            exp_v = exp_q.pop_front();
            got = (i < obs.size()) ? obs[i] : 'x;
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL ovr_first_order[%0d] got=%h exp=%h", i, got, exp_v); end
        end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL ovr_busy got=%b exp=1", busy); end
        checks++; if (fd_cnt != 0)      begin errors++; $display("FAIL ovr_fd_early got=%0d exp=0", fd_cnt); end
        clear_scoreboard();
        repeat (2) @(negedge clk);
        irq_window(10);
        repeat (4) @(negedge clk);
        checks++;
        if (obs.size() != 6) begin errors++; $display("FAIL ovr_second_count got=%0d exp=6", obs.size()); end
        for (int i = 0; i < 6; i++) begin
            exp_v = exp_q.pop_front();
            got = (i < obs.size()) ? obs[i] : 'x;
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL ovr_second_order[%0d] got=%h exp=%h", i, got, exp_v); end
        end
        checks++; if (fd_cnt != 1)      begin errors++; $display("FAIL ovr_fd got=%0d exp=1", fd_cnt); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    endtask

    task automatic test_commit_irq_high();
        logic [43:0] exp_v;
        logic [43:0] got;
        clear_scoreboard();
        push_random(2);
        @(negedge clk);
        irq = 1'b1;
        repeat (2) @(negedge clk);
        do_commit();
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL commit_clears_overrun got=%b exp=0", overrun); end
        repeat (6) @(negedge clk);
        checks++; if (obs.size() != 0) begin errors++; $display("FAIL irqhigh_no_write got=%0d exp=0", obs.size()); end
        checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL irqhigh_busy got=%b exp=1", busy); end
        irq = 1'b0;
        repeat (2) @(negedge clk);
        irq_window(6);
        repeat (4) @(negedge clk);
        checks++;
        if (obs.size() != 2) begin errors++; $display("FAIL irqhigh_count got=%0d exp=2", obs.size()); end
        for (int i = 0; i < 2; i++) begin
            exp_v = exp_q.pop_front();
            got = (i < obs.size()) ? obs[i] : 'x;
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL irqhigh_order[%0d] got=%h exp=%h", i, got, exp_v); end
        end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL irqhigh_fd got=%0d exp=1", fd_cnt); end
    endtask

    task automatic test_empty_commit();
        clear_scoreboard();
        do_commit();
        repeat (2) @(negedge clk);
        irq_window(5);
        repeat (4) @(negedge clk);
        checks++; if (obs.size() != 0) begin errors++; $display("FAIL empty_writes got=%0d exp=0", obs.size()); end
        checks++; if (fd_cnt != 1)     begin errors++; $display("FAIL empty_fd got=%0d exp=1", fd_cnt); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL empty_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_drain();
        logic [43:0] exp_v;
        logic [43:0] got;
        clear_scoreboard();
        push_random(8);
        do_commit();
        repeat (2) @(negedge clk);
        irq = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (write !== 1'b1) begin errors++; $display("FAIL middrain_strobing got=%b exp=1", write); end
        #2 reset = 1'b1;
        #1;
        checks++; if (write !== 1'b0)      begin errors++; $display("FAIL async_write got=%b exp=0", write); end
        checks++; if (chipselect !== 1'b0) begin errors++; $display("FAIL async_cs got=%b exp=0", chipselect); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL async_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL async_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        irq = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        clear_scoreboard();
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (obs.size() != 0)   begin errors++; $display("FAIL post_reset_writes got=%0d exp=0", obs.size()); end
        push_cmd(12'h123, 32'h5555_AAAA);
        do_commit();
        repeat (2) @(negedge clk);
        irq_window(4);
        repeat (4) @(negedge clk);
        checks++;
        if (obs.size() != 1) begin errors++; $display("FAIL post_reset_count got=%0d exp=1", obs.size()); end
        exp_v = exp_q.pop_front();
        got = (obs.size() > 0) ? obs[0] : 'x;
        checks++; if (got !== exp_v) begin errors++; $display("FAIL post_reset_entry got=%h exp=%h", got, exp_v); end
        checks++; if (fd_cnt != 1)   begin errors++; $display("FAIL post_reset_fd got=%0d exp=1", fd_cnt); end
    endtask

    task automatic test_random();
        logic [43:0] exp_v;
        logic [43:0] got;
        int n, r, h, exp_n, guard;
        for (int it = 0; it < 5; it++) begin
            n = $urandom_range(1, 14);
            push_random(n);
            do_commit();
            r = n;
            guard = 0;
            while (r > 0 && guard < 20) begin
                guard++;
                h = $urandom_range(1, 18);
                if (h == r) h = r + 1;
                exp_n = (h < r) ? h : r;
                clear_scoreboard();
                repeat ($urandom_range(2, 4)) @(negedge clk);
                irq_window(h);
                repeat (4) @(negedge clk);
                checks++;
                if (obs.size() != exp_n) begin
                    errors++; $display("FAIL rand_count it=%0d got=%0d exp=%0d", it, obs.size(), exp_n);
                end
                for (int i = 0; i < exp_n; i++) begin
                    exp_v = exp_q.pop_front();
                    got = (i < obs.size()) ? obs[i] : 'x;
                    checks++;
                    if (got !== exp_v) begin errors++; $display("FAIL rand_order it=%0d[%0d] got=%h exp=%h", it, i, got, exp_v); end
                end
                if (h < r) begin
                    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL rand_overrun got=%b exp=1", overrun); end
                    checks++; if (fd_cnt != 0)      begin errors++; $display("FAIL rand_fd_early got=%0d exp=0", fd_cnt); end
                end else begin
                    checks++; if (fd_cnt != 1)    begin errors++; $display("FAIL rand_fd got=%0d exp=1", fd_cnt); end
                    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rand_busy got=%b exp=0", busy); end
                end
                r -= exp_n;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_overrun();
        test_commit_irq_high();
        test_empty_commit();
        test_reset_mid_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
